// File: rtl/fibonacci_gen.sv
// Fibonacci sequencer: steps a 30-bit Fibonacci value at a selectable rate while
// enabled, presents it on io_out[37:8] and pulses wrap when the sequence restarts.
module fibonacci_gen #(
    parameter int CLOCK_WIDTH = 6,
    parameter int VAL_WIDTH   = 30,
    parameter int IO_PADS     = 38
) (
    input  logic                   wb_clk_i,
    input  logic                   reset,
    input  logic                   switch,
    input  logic [CLOCK_WIDTH-1:0] clock_sel,
    output logic [IO_PADS-1:0]     io_out,
    output logic [IO_PADS-1:0]     io_oeb,
    output logic                   wrap,
    output logic                   running
);

    typedef enum logic {
        HOLD = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [VAL_WIDTH-1:0]   cur_q, cur_d;
    logic [VAL_WIDTH-1:0]   nxt_q, nxt_d;
    logic                   ovf_q, ovf_d;
    logic [9:0]             div_q, div_d;
    logic [CLOCK_WIDTH-1:0] sel_q, sel_d;
    logic                   wrap_q, wrap_d;
    logic [VAL_WIDTH:0]     sum_s;
    logic [9:0]             per_m1_s;
    logic                   tick_s;

    // Terminal divider count (4^i - 1) for the lowest set bit i; higher bits lose.
    function automatic logic [9:0] period_m1(input logic [CLOCK_WIDTH-1:0] sel);
        logic [9:0] res;
        res = 10'd0;
        for (int i = CLOCK_WIDTH - 1; i >= 0; i--) begin
            if (sel[i]) begin
                res = 10'((32'd1 << (2 * i)) - 32'd1);
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Next-state logic: run/hold FSM, rate divider and Fibonacci step.
    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        nxt_d    = nxt_q;
        ovf_d    = ovf_q;
        div_d    = div_q;
        sel_d    = clock_sel;
        wrap_d   = 1'b0;
        tick_s   = 1'b0;
        per_m1_s = period_m1(clock_sel);
        sum_s    = {1'b0, cur_q} + {1'b0, nxt_q};
        case (state_q)
            HOLD: begin
                div_d = 10'd0;
                if (switch) begin
                    state_d = RUN;
                end else begin
                    state_d = HOLD;
                end
            end
            RUN: begin
                // A falling switch beats a coincident tick: leave without stepping.
                if (!switch) begin
                    state_d = HOLD;
                    div_d   = 10'd0;
                end else if (clock_sel != sel_q) begin
                    div_d = 10'd0;
                end else if ((clock_sel != {CLOCK_WIDTH{1'b0}}) && (div_q == per_m1_s)) begin
                    tick_s = 1'b1;
                    div_d  = 10'd0;
                end else begin
                    div_d = div_q + 10'd1;
                end
            end
            default: begin
                state_d = HOLD;
                div_d   = 10'd0;
            end
        endcase
        if (tick_s) begin
            if (ovf_q) begin
                cur_d  = {VAL_WIDTH{1'b0}};
                nxt_d  = {{(VAL_WIDTH-1){1'b0}}, 1'b1};
                ovf_d  = 1'b0;
                wrap_d = 1'b1;
            end else begin
                cur_d = nxt_q;
                nxt_d = sum_s[VAL_WIDTH-1:0];
                ovf_d = sum_s[VAL_WIDTH];
            end
        end else begin
            cur_d = cur_d;
        end
    end

    // State register with synchronous reset that overrides every other input.
    always_ff @(posedge wb_clk_i) begin
        if (reset) begin
            state_q <= HOLD;
            cur_q   <= {VAL_WIDTH{1'b0}};
            nxt_q   <= {{(VAL_WIDTH-1){1'b0}}, 1'b1};
            ovf_q   <= 1'b0;
            div_q   <= 10'd0;
            sel_q   <= {CLOCK_WIDTH{1'b0}};
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            nxt_q   <= nxt_d;
            ovf_q   <= ovf_d;
            div_q   <= div_d;
            sel_q   <= sel_d;
            wrap_q  <= wrap_d;
        end
    end

    assign io_out  = {cur_q, 8'h00};
    assign io_oeb  = {{VAL_WIDTH{1'b0}}, 8'hFF};
    assign wrap    = wrap_q;
    assign running = (state_q == RUN);

endmodule

// File: tb/tb_fibonacci_gen.sv
// Self-checking bench for fibonacci_gen: vector table plus a cycle-level scoreboard
// and hand-written sequences for wrap, rate change, hold and reset corner cases.
module tb_fibonacci_gen;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        sw_i = 1'b0;
    logic [5:0]  sel_i = 6'd0;
    logic [37:0] io_out;
    logic [37:0] io_oeb;
    logic        wrap;
    logic        running;
    logic [29:0] dval;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [29:0] F44 = 30'd701408733;
    localparam logic [37:0] OEB_EXP = {30'd0, 8'hFF};

    typedef struct {
        logic        rst;
        logic        sw;
        logic [5:0]  sel;
        logic [29:0] val;
        logic        wr;
        logic        run;
    } vec_t;

    typedef struct {
        logic [29:0] val;
        logic        wr;
        logic        run;
    } exp_t;

    vec_t tab[10];
    exp_t sbq[$];

    logic [29:0] m_cur, m_nxt;
    logic        m_ovf, m_run, m_wrap;
    logic [9:0]  m_div;
    logic [5:0]  m_sel;

    fibonacci_gen dut (
        .wb_clk_i (clk),
        .reset    (rst_i),
        .switch   (sw_i),
        .clock_sel(sel_i),
        .io_out   (io_out),
        .io_oeb   (io_oeb),
        .wrap     (wrap),
        .running  (running)
    );

    always #5 clk = ~clk;
    assign dval = io_out[37:8];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // Behavioural reference: one call per clock edge.
    task automatic model_adv(input logic r, input logic sw, input logic [5:0] s);
        logic [30:0] sm;
        logic [9:0]  pm;
        int          lb;
        lb = -1;
        for (int i = 5; i >= 0; i--) if (s[i]) lb = i;
        pm = 10'd0;
        for (int k = 0; k < lb; k++) pm = pm * 10'd4 + 10'd3;
        if (r) begin
            m_cur = 30'd0; m_nxt = 30'd1; m_ovf = 1'b0; m_run = 1'b0;
            m_wrap = 1'b0; m_div = 10'd0; m_sel = 6'd0;
        end else begin
            m_wrap = 1'b0;
            if (!m_run) begin
                m_run = sw; m_div = 10'd0;
            end else if (!sw) begin
                m_run = 1'b0; m_div = 10'd0;
            end else if (s != m_sel) begin
                m_div = 10'd0;
            end else if (lb >= 0 && m_div == pm) begin
                m_div = 10'd0;
                if (m_ovf) begin
                    m_cur = 30'd0; m_nxt = 30'd1; m_ovf = 1'b0; m_wrap = 1'b1;
                end else begin
                    sm = {1'b0, m_cur} + {1'b0, m_nxt};
                    m_cur = m_nxt; m_nxt = sm[29:0]; m_ovf = sm[30];
                end
            end else begin
                m_div = m_div + 10'd1;
            end
            m_sel = s;
        end
    endtask

    task automatic drive_check(input logic r, input logic sw, input logic [5:0] s);
        exp_t e;
        @(negedge clk);
        rst_i = r; sw_i = sw; sel_i = s;
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sbq.pop_front();
            chk("sb_val", {2'b0, dval}, {2'b0, e.val});
            chk("sb_wrap", {31'd0, wrap}, {31'd0, e.wr});
            chk("sb_run", {31'd0, running}, {31'd0, e.run});
        end
        chk("pad_out_lo", {24'd0, io_out[7:0]}, 32'd0);
        chk("pad_oeb", {31'd0, (io_oeb === OEB_EXP)}, 32'd1);
    endtask

    task automatic cycle_m(input logic r, input logic sw, input logic [5:0] s);
        exp_t e;
        model_adv(r, sw, s);
        e.val = m_cur; e.wr = m_wrap; e.run = m_run;
        sbq.push_back(e);
        drive_check(r, sw, s);
    endtask

    task automatic run_until(input string nm, input logic [29:0] target, input logic [5:0] s);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 120 && !found; i++) begin
            cycle_m(1'b0, 1'b1, s);
            if (dval == target) found = 1'b1;
        end
        chk(nm, {31'd0, found}, 32'd1);
    endtask

    initial begin
        exp_t        e;
        logic [29:0] prev;
        int          k;
        bit          seen;

        tab[0] = '{1'b1, 1'b0, 6'd0, 30'd0,  1'b0, 1'b0};
        tab[1] = '{1'b1, 1'b1, 6'd1, 30'd0,  1'b0, 1'b0};
        tab[2] = '{1'b0, 1'b1, 6'd1, 30'd0,  1'b0, 1'b1};
        tab[3] = '{1'b0, 1'b1, 6'd1, 30'd1,  1'b0, 1'b1};
        tab[4] = '{1'b0, 1'b1, 6'd1, 30'd1,  1'b0, 1'b1};
        tab[5] = '{1'b0, 1'b1, 6'd1, 30'd2,  1'b0, 1'b1};
        tab[6] = '{1'b0, 1'b1, 6'd1, 30'd3,  1'b0, 1'b1};
        tab[7] = '{1'b0, 1'b1, 6'd1, 30'd5,  1'b0, 1'b1};
        tab[8] = '{1'b0, 1'b1, 6'd1, 30'd8,  1'b0, 1'b1};
        tab[9] = '{1'b0, 1'b1, 6'd1, 30'd13, 1'b0, 1'b1};

        for (int i = 0; i < 10; i++) begin
            model_adv(tab[i].rst, tab[i].sw, tab[i].sel);
            e.val = tab[i].val; e.wr = tab[i].wr; e.run = tab[i].run;
            sbq.push_back(e);
            drive_check(tab[i].rst, tab[i].sw, tab[i].sel);
        end

        // Free run to the largest 30-bit value, then the wrap.
        run_until("reach_f44", F44, 6'd1);
        cycle_m(1'b0, 1'b1, 6'd1);
        chk("wrap_val", {2'b0, dval}, 32'd0);
        chk("wrap_pulse", {31'd0, wrap}, 32'd1);
        cycle_m(1'b0, 1'b1, 6'd1);
        chk("post_wrap_1", {2'b0, dval}, 32'd1);
        chk("wrap_one_cycle", {31'd0, wrap}, 32'd0);
        cycle_m(1'b0, 1'b1, 6'd1);
        chk("post_wrap_1b", {2'b0, dval}, 32'd1);
        cycle_m(1'b0, 1'b1, 6'd1);
        chk("post_wrap_2", {2'b0, dval}, 32'd2);

        // Period 16, then switch to period 4 mid-count.
        cycle_m(1'b0, 1'b1, 6'b000100);
        prev = dval; seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            cycle_m(1'b0, 1'b1, 6'b000100);
            if (dval != prev) seen = 1'b1;
        end
        chk("p16_first_step", {31'd0, seen}, 32'd1);
        prev = dval; k = 0; seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            cycle_m(1'b0, 1'b1, 6'b000100);
            k++;
            if (dval != prev) seen = 1'b1;
        end
        chk("p16_gap", k, 32'd16);
        repeat (5) cycle_m(1'b0, 1'b1, 6'b000100);
        prev = dval;
        cycle_m(1'b0, 1'b1, 6'b000010);
        k = 0; seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            cycle_m(1'b0, 1'b1, 6'b000010);
            k++;
            if (dval != prev) seen = 1'b1;
        end
        chk("sel_change_gap", k, 32'd4);

        // clock_sel = 0: paused while still running.
        cycle_m(1'b0, 1'b1, 6'd0);
        prev = dval;
        repeat (50) cycle_m(1'b0, 1'b1, 6'd0);
        chk("sel0_frozen", {2'b0, dval}, {2'b0, prev});
        chk("sel0_running", {31'd0, running}, 32'd1);

        // Hold at 21 for 100 cycles, then resume.
        cycle_m(1'b1, 1'b0, 6'd1);
        run_until("reach_21", 30'd21, 6'd1);
        cycle_m(1'b0, 1'b0, 6'd1);
        chk("hold_running", {31'd0, running}, 32'd0);
        chk("hold_val", {2'b0, dval}, 32'd21);
        repeat (100) cycle_m(1'b0, 1'b0, 6'd1);
        chk("hold_100", {2'b0, dval}, 32'd21);
        cycle_m(1'b0, 1'b1, 6'd1);
        chk("resume_edge", {2'b0, dval}, 32'd21);
        cycle_m(1'b0, 1'b1, 6'd1);
        chk("resume_34", {2'b0, dval}, 32'd34);

        // Reset while an overflow restart is pending.
        run_until("reach_f44_b", F44, 6'd1);
        cycle_m(1'b1, 1'b1, 6'd1);
        chk("rst_val", {2'b0, dval}, 32'd0);
        chk("rst_wrap", {31'd0, wrap}, 32'd0);
        chk("rst_running", {31'd0, running}, 32'd0);
        cycle_m(1'b0, 1'b1, 6'd1);
        chk("rel_val0", {2'b0, dval}, 32'd0);
        chk("rel_running", {31'd0, running}, 32'd1);
        cycle_m(1'b0, 1'b1, 6'd1);
        chk("rel_val1", {2'b0, dval}, 32'd1);
        chk("rel_nowrap", {31'd0, wrap}, 32'd0);
        cycle_m(1'b0, 1'b1, 6'd1);
        chk("rel_val1b", {2'b0, dval}, 32'd1);
        chk("rel_nowrap_b", {31'd0, wrap}, 32'd0);

        chk("sb_drained", sbq.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
